// File: rtl/bec_io_bridge.sv
//------------------------------------------------------------------------------
// Module  : bec_io_bridge
// Brief   : Serial-to-parallel operand loader, key-bit handshake and serial
//           result unloader wrapped around a 163-bit BEC arithmetic core.
//           Optional PROC watchdog: define BEC_IO_BRIDGE_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bec_io_bridge (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         upload_req,
    input  logic         w1,
    input  logic         z1,
    input  logic         w2,
    input  logic         z2,
    input  logic         inv_w0,
    input  logic         d,
    input  logic         ki,
    input  logic         master_ena_proc,
    output logic         load_data,
    output logic         next_key,
    output logic [3:0]   becStatus,
    output logic         slv_done,
    output logic         wout,
    output logic         zout,
    output logic [162:0] core_w1,
    output logic [162:0] core_z1,
    output logic [162:0] core_w2,
    output logic [162:0] core_z2,
    output logic [162:0] core_inv_w0,
    output logic [162:0] core_d,
    output logic         core_start,
    input  logic         core_key_req,
    output logic         core_key_bit,
    input  logic         core_done,
    input  logic [162:0] core_wout,
    input  logic [162:0] core_zout
);

    localparam logic [7:0] C_LD_LAST = 8'd162;
    localparam logic [7:0] C_KEY_MAX = 8'd163;
    localparam logic [7:0] C_UN_LAST = 8'd163;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LDONE  = 3'd2,
        S_PROC   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_ld_cnt;
    logic [7:0]     r_key_cnt;
    logic [7:0]     r_un_cnt;
    logic           r_err;
    logic           r_core_start;
    logic           r_slv_done;
    logic [162:0]   r_wsh;
    logic [162:0]   r_zsh;
    logic           w_in_proc;
    logic           w_next_key;
    logic           w_key_ovf;
    logic           w_err_set;
    logic           w_timeout;
    logic           w_un_active;
    logic           w_un_last;

`ifdef BEC_IO_BRIDGE_TIMEOUT_EN
    logic [15:0]    r_wdog;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wdog <= 16'd0;
        end else if (r_state == S_PROC) begin
            r_wdog <= r_wdog + 16'd1;
        end else begin
            r_wdog <= 16'd0;
        end
    end

    assign w_timeout = w_in_proc && (r_wdog == 16'hFFFF);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_in_proc   = (r_state == S_PROC);
    assign w_next_key  = w_in_proc && core_key_req && (r_key_cnt < C_KEY_MAX);
    assign w_key_ovf   = w_in_proc && core_key_req && (r_key_cnt >= C_KEY_MAX);
    // Cycle 0 of UNLOAD carries the slv_done pulse; bits follow from cycle 1.
    assign w_un_active = (r_state == S_UNLOAD) && (r_un_cnt != 8'd0);
    assign w_un_last   = (r_state == S_UNLOAD) && (r_un_cnt == C_UN_LAST);

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (upload_req) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_ld_cnt == C_LD_LAST) w_next = S_LDONE;
            end
            S_LDONE: begin
                if (master_ena_proc) w_next = S_PROC;
            end
            S_PROC: begin
                if (core_done) begin
                    w_next = S_UNLOAD;
                end else if (!master_ena_proc || w_timeout) begin
                    w_next    = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            S_UNLOAD: begin
                if (r_un_cnt == C_UN_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= S_IDLE;
            r_ld_cnt     <= 8'd0;
            r_key_cnt    <= 8'd0;
            r_un_cnt     <= 8'd0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
            r_slv_done   <= 1'b0;
            r_wsh        <= '0;
            r_zsh        <= '0;
            core_w1      <= '0;
            core_z1      <= '0;
            core_w2      <= '0;
            core_z2      <= '0;
            core_inv_w0  <= '0;
            core_d       <= '0;
        end else begin
            r_state      <= w_next;
            r_core_start <= (r_state == S_LDONE) && (w_next == S_PROC);
            r_slv_done   <= w_in_proc && (w_next == S_UNLOAD);

            if ((r_state == S_IDLE) && (w_next == S_LOAD)) begin
                r_err <= 1'b0;
            end else if (w_err_set || w_key_ovf) begin
                r_err <= 1'b1;
            end

            if (r_state == S_LOAD) begin
                core_w1     <= {core_w1[161:0],     w1};
                core_z1     <= {core_z1[161:0],     z1};
                core_w2     <= {core_w2[161:0],     w2};
                core_z2     <= {core_z2[161:0],     z2};
                core_inv_w0 <= {core_inv_w0[161:0], inv_w0};
                core_d      <= {core_d[161:0],      d};
                r_ld_cnt    <= (r_ld_cnt == C_LD_LAST) ? 8'd0 : r_ld_cnt + 8'd1;
            end

            if (!w_in_proc) begin
                r_key_cnt <= 8'd0;
            end else if (w_next_key) begin
                r_key_cnt <= r_key_cnt + 8'd1;
            end

            if (w_in_proc && core_done) begin
                r_wsh    <= core_wout;
                r_zsh    <= core_zout;
                r_un_cnt <= 8'd0;
            end else if (r_state == S_UNLOAD) begin
                r_un_cnt <= (r_un_cnt == C_UN_LAST) ? 8'd0 : r_un_cnt + 8'd1;
                if (r_un_cnt != 8'd0) begin
                    r_wsh <= {r_wsh[161:0], 1'b0};
                    r_zsh <= {r_zsh[161:0], 1'b0};
                end
            end
        end
    end

    assign load_data    = (r_state == S_LOAD);
    assign next_key     = w_next_key;
    assign core_key_bit = w_in_proc && ki;
    assign core_start   = r_core_start;
    assign slv_done     = r_slv_done;
    assign wout         = w_un_active && r_wsh[162];
    assign zout         = w_un_active && r_zsh[162];
    assign becStatus    = {r_err, (r_state == S_LDONE), w_in_proc, w_un_last};

endmodule

`default_nettype wire

// File: tb/tb_bec_io_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_bec_io_bridge
// Brief   : Randomized scoreboard bench for bec_io_bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bec_io_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         upload_req, w1, z1, w2, z2, inv_w0, d, ki, master_ena_proc;
    logic         load_data, next_key, slv_done, wout, zout;
    logic [3:0]   becStatus;
    logic [162:0] core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d;
    logic         core_start, core_key_req, core_key_bit, core_done;
    logic [162:0] core_wout, core_zout;

    bec_io_bridge dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .upload_req      (upload_req),
        .w1              (w1),
        .z1              (z1),
        .w2              (w2),
        .z2              (z2),
        .inv_w0          (inv_w0),
        .d               (d),
        .ki              (ki),
        .master_ena_proc (master_ena_proc),
        .load_data       (load_data),
        .next_key        (next_key),
        .becStatus       (becStatus),
        .slv_done        (slv_done),
        .wout            (wout),
        .zout            (zout),
        .core_w1         (core_w1),
        .core_z1         (core_z1),
        .core_w2         (core_w2),
        .core_z2         (core_z2),
        .core_inv_w0     (core_inv_w0),
        .core_d          (core_d),
        .core_start      (core_start),
        .core_key_req    (core_key_req),
        .core_key_bit    (core_key_bit),
        .core_done       (core_done),
        .core_wout       (core_wout),
        .core_zout       (core_zout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [162:0] w;
        logic [162:0] z;
    } res_t;

    res_t         exp_q[$];
    logic [162:0] op_v [6];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_start  = 0;
    int           n_unload = 0;
    int           model_kcnt;
    logic         model_err;

    task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [162:0] rnd163();
        logic [162:0] v = '0;
        for (int i = 0; i < 6; i++) v = {v[130:0], 32'($urandom())};
        return v;
    endfunction

    task automatic check_all_zero(input string name);
        chk(name, {load_data, next_key, becStatus, slv_done, wout, zout, core_start, core_key_bit}, '0);
        chk({name, "_operands"}, core_w1 | core_z1 | core_w2 | core_z2 | core_inv_w0 | core_d, '0);
    endtask

    always @(negedge clk) if (core_start) n_start++;

    // Result monitor: every slv_done pulse must be followed by one expected unload.
    initial begin
        res_t         r;
        logic [162:0] gw, gz, gs, gd;
        forever begin
            @(negedge clk);
            if (rst_n && slv_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_slv_done", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("wout_in_slv_done_cycle", {wout, zout}, 0);
                    gw = '0; gz = '0; gs = '0; gd = '0;
                    for (int i = 162; i >= 0; i--) begin
                        @(negedge clk);
                        gw[i] = wout;
                        gz[i] = zout;
                        gs[i] = becStatus[0];
                        gd[i] = slv_done;
                    end
                    chk("wout_stream", gw, r.w);
                    chk("zout_stream", gz, r.z);
                    chk("unload_last_flag", gs, 163'h1);
                    chk("slv_done_width", gd, 0);
                    @(negedge clk);
                    chk("outputs_after_unload", {slv_done, wout, zout, becStatus[2:0]}, 0);
                    n_unload++;
                end
            end
        end
    end

    task automatic load_ops(input int abort_at);
        int n = 0;
        int g = 0;
        master_ena_proc = 1'b0;
        @(negedge clk);
        upload_req = 1'b1;
        @(negedge clk);
        while (!load_data && g < 10) begin
            @(negedge clk);
            g++;
        end
        upload_req = 1'b0;
        chk("load_started", load_data, 1);
        chk("err_cleared_on_upload", becStatus[3], 0);
        model_err = 1'b0;
        while (load_data && g < 400) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_midload");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (n < 163) begin
                w1 = op_v[0][162-n]; z1 = op_v[1][162-n]; w2 = op_v[2][162-n];
                z2 = op_v[3][162-n]; inv_w0 = op_v[4][162-n]; d = op_v[5][162-n];
            end
            n++;
            @(negedge clk);
            g++;
        end
        chk("load_strobes", n, 163);
        chk("core_w1", core_w1, op_v[0]);
        chk("core_z1", core_z1, op_v[1]);
        chk("core_w2", core_w2, op_v[2]);
        chk("core_z2", core_z2, op_v[3]);
        chk("core_inv_w0", core_inv_w0, op_v[4]);
        chk("core_d", core_d, op_v[5]);
        chk("status_ldone", becStatus, 4'b0100);
    endtask

    task automatic enter_proc();
        int s0 = n_start;
        int g  = 0;
        master_ena_proc = 1'b1;
        @(negedge clk);
        while (!becStatus[1] && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("proc_entered", becStatus, {model_err, 3'b010});
        model_kcnt = 0;
        repeat (2) @(negedge clk);
        chk("core_start_pulses", n_start - s0, 1);
    endtask

    task automatic key_pulses(input int n, input bit poke);
        logic exp_nk;
        for (int k = 0; k < n; k++) begin
            core_key_req = 1'b1;
            ki = 1'($urandom_range(0, 1));
            if (poke && k == 5) upload_req = 1'b1;
            #1;
            exp_nk = (model_kcnt < 163);
            chk("next_key", next_key, exp_nk);
            chk("core_key_bit", core_key_bit, ki);
            if (exp_nk) model_kcnt++;
            else model_err = 1'b1;
            @(negedge clk);
            core_key_req = 1'b0;
            upload_req   = 1'b0;
            chk("status_in_proc", becStatus, {model_err, 3'b010});
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic finish_core(input logic [162:0] w, input logic [162:0] z, input bit drop);
        int   u0 = n_unload;
        int   g  = 0;
        res_t r;
        core_done = 1'b1;
        core_wout = w;
        core_zout = z;
        if (drop) master_ena_proc = 1'b0;
        r.w = w;
        r.z = z;
        exp_q.push_back(r);
        @(negedge clk);
        core_done = 1'b0;
        core_wout = rnd163();
        core_zout = rnd163();
        while (n_unload == u0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("unload_completed", n_unload != u0, 1);
        chk("status_after_unload", becStatus, {model_err, 3'b000});
        master_ena_proc = 1'b0;
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < 6; i++) op_v[i] = rnd163();
    endtask

    initial begin
        rst_n = 1'b0; upload_req = 1'b0; master_ena_proc = 1'b0;
        w1 = 1'b0; z1 = 1'b0; w2 = 1'b0; z2 = 1'b0; inv_w0 = 1'b0; d = 1'b0;
        ki = 1'b1; core_key_req = 1'b1; core_done = 1'b0;
        core_wout = '0; core_zout = '0;
        model_err = 1'b0; model_kcnt = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        ki = 1'b0; core_key_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {becStatus, load_data}, 0);

        // Alternating w1 pattern, full key sequence, single-one / all-ones results
        rnd_ops();
        for (int i = 0; i < 163; i++) op_v[0][i] = (i % 2 == 0);
        load_ops(-1);
        enter_proc();
        key_pulses(163, 1'b1);
        chk("err_after_163_keys", becStatus[3], 0);
        finish_core(163'h1, '1, 1'b0);

        // Random loads and results
        for (int t = 0; t < 3; t++) begin
            rnd_ops();
            load_ops(-1);
            enter_proc();
            key_pulses($urandom_range(1, 40), 1'b0);
            finish_core(rnd163(), rnd163(), 1'b0);
        end

        // Key overflow: 164th request is refused and error is sticky
        rnd_ops();
        load_ops(-1);
        enter_proc();
        key_pulses(164, 1'b0);
        finish_core(rnd163(), rnd163(), 1'b0);
        repeat (3) @(negedge clk);
        chk("err_sticky_in_idle", becStatus, 4'b1000);

        // Reset during load, then a fresh full load
        rnd_ops();
        load_ops(80);
        model_err = 1'b0;
        @(negedge clk);
        chk("idle_after_midload_reset", {becStatus, load_data}, 0);
        rnd_ops();
        load_ops(-1);
        enter_proc();
        finish_core(rnd163(), rnd163(), 1'b0);

        // Enable dropped in PROC without core_done
        rnd_ops();
        load_ops(-1);
        enter_proc();
        key_pulses(3, 1'b0);
        master_ena_proc = 1'b0;
        @(negedge clk);
        model_err = 1'b1;
        chk("ena_drop_status", {becStatus, slv_done, wout}, 6'b100000);

        // core_done coincident with enable drop: completion wins
        rnd_ops();
        load_ops(-1);
        enter_proc();
        finish_core(rnd163(), rnd163(), 1'b1);

        // Watchdog behaviour
        rnd_ops();
        load_ops(-1);
        enter_proc();
`ifdef BEC_IO_BRIDGE_TIMEOUT_EN
        begin
            int g;
            g = 0;
            while (becStatus[1] && g < 66000) begin
                @(negedge clk);
                g++;
            end
            model_err = 1'b1;
            chk("timeout_status", becStatus, 4'b1000);
            chk("timeout_latency_ok", (g > 65000), 1);
        end
`else
        repeat (70000) @(negedge clk);
        chk("no_timeout_still_proc", becStatus, 4'b0010);
        master_ena_proc = 1'b0;
        @(negedge clk);
        model_err = 1'b1;
        chk("exit_after_long_proc", becStatus, 4'b1000);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
